// File: rtl/input_conditioner.sv
// input_conditioner: per-channel synchronizer + debounce FSM for pad inputs.
// Produces a clean level with one-cycle rise/fall pulses per channel.
// Optional auto-repeat on held-high channels: define INPUT_REPEAT_EN.

module input_conditioner_lane #(
  parameter int SYNC_BITS       = 3,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 1000,
  parameter int REPEAT_PERIOD   = 250
) (
  input  logic clock,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall,
  output logic repeat_pulse
);
  typedef enum logic [1:0] {STABLE_LOW, PEND_HIGH, STABLE_HIGH, PEND_LOW} state_t;

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [SYNC_BITS-1:0] sync_q;
  logic                 synced;
  state_t               state;
  logic [CW-1:0]        cnt;

  // Plain shift-register synchronizer; MSB is the metastability-safe copy.
  always_ff @(posedge clock) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_BITS-2:0], din};
  end

  assign synced = sync_q[SYNC_BITS-1];

  // Debounce FSM: a new level is accepted after DEBOUNCE_CYCLES equal synced samples.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= STABLE_LOW;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      case (state)
        STABLE_LOW: if (synced) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state <= STABLE_HIGH;
            level <= 1'b1;
            rise  <= 1'b1;
          end else begin
            state <= PEND_HIGH;
            cnt   <= CNT_ONE;
          end
        end
        PEND_HIGH: if (!synced) begin
          state <= STABLE_LOW;
          cnt   <= '0;
        end else if (cnt == CNT_LAST) begin
          state <= STABLE_HIGH;
          cnt   <= '0;
          level <= 1'b1;
          rise  <= 1'b1;
        end else begin
          cnt <= cnt + CNT_ONE;
        end
        STABLE_HIGH: if (!synced) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state <= STABLE_LOW;
            level <= 1'b0;
            fall  <= 1'b1;
          end else begin
            state <= PEND_LOW;
            cnt   <= CNT_ONE;
          end
        end
        PEND_LOW: if (synced) begin
          state <= STABLE_HIGH;
          cnt   <= '0;
        end else if (cnt == CNT_LAST) begin
          state <= STABLE_LOW;
          cnt   <= '0;
          level <= 1'b0;
          fall  <= 1'b1;
        end else begin
          cnt <= cnt + CNT_ONE;
        end
        default: begin
          state <= STABLE_LOW;
          cnt   <= '0;
        end
      endcase
    end
  end

`ifdef INPUT_REPEAT_EN
  localparam int TW = $clog2(REPEAT_DELAY + REPEAT_PERIOD + 1);
  localparam logic [TW-1:0] T_DLY = TW'(REPEAT_DELAY);
  localparam logic [TW-1:0] T_END = TW'(REPEAT_DELAY + REPEAT_PERIOD);

  logic [TW-1:0] tmr;
  logic [TW-1:0] tmr_nxt;

  assign tmr_nxt = tmr + TW'(1);

  // Dwell timer in STABLE_HIGH; after the first pulse it folds back to
  // REPEAT_DELAY so every later pulse is REPEAT_PERIOD apart.
  always_ff @(posedge clock) begin
    if (reset) begin
      tmr          <= '0;
      repeat_pulse <= 1'b0;
    end else begin
      repeat_pulse <= 1'b0;
      if (state == STABLE_HIGH && synced) begin
        if (tmr_nxt == T_DLY) begin
          repeat_pulse <= 1'b1;
          tmr          <= tmr_nxt;
        end else if (tmr_nxt == T_END) begin
          repeat_pulse <= 1'b1;
          tmr          <= T_DLY;
        end else begin
          tmr <= tmr_nxt;
        end
      end else begin
        tmr <= '0;
      end
    end
  end
`else
  localparam int unused_rpt_cfg = REPEAT_DELAY + REPEAT_PERIOD;
  assign repeat_pulse = 1'b0;
`endif
endmodule

module input_conditioner #(
  parameter int NUM_INPUTS      = 4,
  parameter int SYNC_BITS       = 3,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 1000,
  parameter int REPEAT_PERIOD   = 250
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NUM_INPUTS-1:0] in,
  output logic [NUM_INPUTS-1:0] level,
  output logic [NUM_INPUTS-1:0] rise,
  output logic [NUM_INPUTS-1:0] fall,
  output logic [NUM_INPUTS-1:0] repeat_pulse,
  output logic                  any_event
);
  // Channels are fully independent; one lane instance each.
  for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_lane
    input_conditioner_lane #(
      .SYNC_BITS      (SYNC_BITS),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_lane (
      .clock       (clock),
      .reset       (reset),
      .din         (in[g]),
      .level       (level[g]),
      .rise        (rise[g]),
      .fall        (fall[g]),
      .repeat_pulse(repeat_pulse[g])
    );
  end

  assign any_event = |(rise | fall);
endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner: directed scenarios plus random toggling,
// all checked against a sample-history reference model.
module tb_input_conditioner;
  localparam int N = 4, SB = 3, DB = 4, RD = 10, RP = 5;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [N-1:0] in = '0;
  logic [N-1:0] level, rise, fall, repeat_pulse;
  logic any_event;

  int checks = 0, errors = 0;

  input_conditioner #(.NUM_INPUTS(N), .SYNC_BITS(SB), .DEBOUNCE_CYCLES(DB),
                      .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
    .clock(clock), .reset(reset), .in(in), .level(level), .rise(rise),
    .fall(fall), .repeat_pulse(repeat_pulse), .any_event(any_event));

  always #5 clock = ~clock;

  // Reference model: the value the debouncer sees at an edge is the raw input
  // from SB edges earlier (0 right after reset). A channel flips when its last
  // DB seen samples since the previous flip all differ from the current level.
  logic [N-1:0] raw_q[$];
  logic [N-1:0] seen_q[$];
  logic [N-1:0] m_level, m_rise, m_fall, m_rep, m_seen;
  logic         m_all;
  int           flip_at[N];
  int           hi_start[N];
  int           ecnt;
`ifdef INPUT_REPEAT_EN
  int           m_k;
`endif

  task automatic model_step;
    if (reset) begin
      raw_q.delete(); seen_q.delete();
      m_level = '0; m_rise = '0; m_fall = '0; m_rep = '0;
      for (int i = 0; i < N; i++) begin flip_at[i] = 0; hi_start[i] = -1; end
    end else begin
      m_seen = (raw_q.size() >= SB) ? raw_q[raw_q.size()-SB] : '0;
      raw_q.push_back(in);
      seen_q.push_back(m_seen);
      ecnt = seen_q.size();
      m_rise = '0; m_fall = '0; m_rep = '0;
      for (int i = 0; i < N; i++) begin
        m_all = (ecnt - flip_at[i] >= DB);
        if (m_all)
          for (int k = 0; k < DB; k++)
            if (seen_q[ecnt-1-k][i] == m_level[i]) m_all = 1'b0;
        if (m_all) begin
          m_level[i] = ~m_level[i];
          flip_at[i] = ecnt;
          if (m_level[i]) begin m_rise[i] = 1'b1; hi_start[i] = ecnt - 1; end
          else begin m_fall[i] = 1'b1; hi_start[i] = -1; end
        end else if (m_level[i]) begin
          if (!m_seen[i]) hi_start[i] = -1;
          else if (hi_start[i] < 0) hi_start[i] = ecnt - 1;
`ifdef INPUT_REPEAT_EN
          else begin
            m_k = ecnt - 1 - hi_start[i];
            if (m_k >= RD && (m_k - RD) % RP == 0) m_rep[i] = 1'b1;
          end
`endif
        end
      end
    end
  endtask

  always @(posedge clock) model_step();

  logic [4*N:0] obs_v, exp_v;
  assign obs_v = {level, rise, fall, repeat_pulse, any_event};
  assign exp_v = {m_level, m_rise, m_fall, m_rep, |(m_rise | m_fall)};

  task automatic settle(input logic [N-1:0] v, input int n);
    in = v;
    repeat (n) @(negedge clock);
  endtask

  task automatic test_reset;
    logic [N-1:0] er;
    reset = 1'b1; in = '1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clock);
      checks++;
      if ({level, rise, fall, repeat_pulse} !== '0) begin
        errors++; $display("FAIL reset_clear c=%0d got %h exp 0", c, {level, rise, fall, repeat_pulse});
      end
    end
    reset = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clock);
      er = (c == 7) ? {N{1'b1}} : '0;
      checks++;
      if (rise !== er) begin errors++; $display("FAIL reset_release_rise c=%0d got %h exp %h", c, rise, er); end
      checks++;
      if (obs_v !== exp_v) begin errors++; $display("FAIL model_reset c=%0d got %h exp %h", c, obs_v, exp_v); end
    end
  endtask

  task automatic test_single;
    settle('0, 12);
    for (int ph = 0; ph < 2; ph++) begin
      in = (ph == 0) ? 4'b0001 : 4'b0000;
      for (int c = 0; c < 20; c++) begin
        @(negedge clock);
        checks++;
        if ({level[0], rise[0], fall[0]} !== {(c >= 6) ^ (ph == 1), (c == 6) && ph == 0, (c == 6) && ph == 1}) begin
          errors++; $display("FAIL single_ch0 ph=%0d c=%0d got %b exp level/rise/fall per edge 6", ph, c, {level[0], rise[0], fall[0]});
        end
        checks++;
        if (obs_v !== exp_v) begin errors++; $display("FAIL model_single c=%0d got %h exp %h", c, obs_v, exp_v); end
      end
    end
  endtask

  task automatic test_glitch;
    settle('0, 12);
    for (int c = 0; c < 16; c++) begin
      in = (c < 3) ? 4'b0010 : 4'b0000;
      @(negedge clock);
      checks++;
      if ({rise[1], level[1], any_event} !== 3'b000) begin
        errors++; $display("FAIL glitch c=%0d got %b exp 000", c, {rise[1], level[1], any_event});
      end
      checks++;
      if (obs_v !== exp_v) begin errors++; $display("FAIL model_glitch c=%0d got %h exp %h", c, obs_v, exp_v); end
    end
  endtask

  task automatic test_bounce;
    int nrise = 0;
    settle('0, 8);
    for (int c = 0; c < 30; c++) begin
      in = (c >= 12 || (c / 2) % 2 == 0) ? 4'b0100 : 4'b0000;
      @(negedge clock);
      if (rise[2]) nrise++;
      checks++;
      if (rise[2] !== (c == 18)) begin errors++; $display("FAIL bounce_rise c=%0d got %b exp %b", c, rise[2], c == 18); end
      checks++;
      if (obs_v !== exp_v) begin errors++; $display("FAIL model_bounce c=%0d got %h exp %h", c, obs_v, exp_v); end
    end
    checks++;
    if (nrise != 1) begin errors++; $display("FAIL bounce_count got %0d exp 1", nrise); end
  endtask

  task automatic test_simul;
    int nev = 0;
    settle('0, 12);
    in = 4'b1001;
    for (int c = 0; c < 12; c++) begin
      @(negedge clock);
      if (any_event) nev++;
      checks++;
      if ({rise, any_event} !== ((c == 6) ? 5'b10011 : 5'b00000)) begin
        errors++; $display("FAIL simul c=%0d got %b exp rise=1001 any=1 at c=6", c, {rise, any_event});
      end
      checks++;
      if (obs_v !== exp_v) begin errors++; $display("FAIL model_simul c=%0d got %h exp %h", c, obs_v, exp_v); end
    end
    checks++;
    if (nev != 1) begin errors++; $display("FAIL simul_any_count got %0d exp 1", nev); end
  endtask

  task automatic test_reset_pend;
    settle('0, 12);
    in = 4'b0010;
    for (int c = 0; c < 16; c++) begin
      reset = (c == 4);
      @(negedge clock);
      checks++;
      if (rise[1] !== (c == 11)) begin errors++; $display("FAIL reset_pend_rise c=%0d got %b exp %b", c, rise[1], c == 11); end
      checks++;
      if (obs_v !== exp_v) begin errors++; $display("FAIL model_reset_pend c=%0d got %h exp %h", c, obs_v, exp_v); end
    end
    reset = 1'b0;
  endtask

  task automatic test_repeat;
    int  rise_c = -1;
    logic er;
    settle('0, 12);
    in = 4'b0001;
    for (int c = 0; c < 37; c++) begin
      @(negedge clock);
      if (rise[0] && rise_c < 0) rise_c = c;
      if (rise_c >= 0 && c > rise_c) begin
`ifdef INPUT_REPEAT_EN
        er = (c - rise_c >= RD) && ((c - rise_c - RD) % RP == 0);
`else
        er = 1'b0;
`endif
        checks++;
        if (repeat_pulse[0] !== er) begin
          errors++; $display("FAIL repeat_hold k=%0d got %b exp %b", c - rise_c, repeat_pulse[0], er);
        end
      end
      checks++;
      if (obs_v !== exp_v) begin errors++; $display("FAIL model_repeat c=%0d got %h exp %h", c, obs_v, exp_v); end
    end
    checks++;
    if (rise_c != 6) begin errors++; $display("FAIL repeat_rise_time got %0d exp 6", rise_c); end
    in = '0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      checks++;
      if (repeat_pulse !== '0) begin errors++; $display("FAIL repeat_release c=%0d got %h exp 0", c, repeat_pulse); end
    end
  endtask

  task automatic test_random;
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(5) == 0) in[i] = ~in[i];
      reset = ($urandom_range(199) == 0);
      @(negedge clock);
      checks++;
      if (obs_v !== exp_v) begin errors++; $display("FAIL model_random c=%0d got %h exp %h", c, obs_v, exp_v); end
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset;
    test_single;
    test_glitch;
    test_bounce;
    test_simul;
    test_reset_pend;
    test_repeat;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
